sha256_block_sequencer: RTL

Controller that sequences multi-block SHA-256 messages through the `sha256_compressor` core. It accepts padded 512-bit blocks from an upstream padder over a valid/ready stream and buffers up to two of them. It issues each block to the core with the correct chaining value (IV for the first block, previous result after that). When the block marked last completes, it presents the 256-bit digest on a valid/ready output.

---
 rtl/sha256_block_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sha256_block_sequencer.sv
// Sequences padded 512-bit blocks through an external SHA-256 compressor,
// chaining intermediate hashes and presenting the final digest on a valid/ready port.
module sha256_block_sequencer #(
  parameter logic [255:0] IV             = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19,
  parameter int unsigned  TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_last,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [255:0] digest,
  output logic         busy,
  output logic         err_timeout,
  output logic         core_start,
  output logic [511:0] core_block,
  output logic [255:0] core_hash_in,
  input  logic         core_ready,
  input  logic         core_done,
  input  logic [255:0] core_hash
);

  localparam int unsigned BLK_W  = 512;
  localparam int unsigned HASH_W = 256;
  localparam int unsigned ENT_W  = BLK_W + 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OUT, S_ERR} state_e;

  state_e             state_q, state_d;
  logic [ENT_W-1:0]   fifo_q [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;
  logic [HASH_W-1:0]  h_q, h_d;
  logic [HASH_W-1:0]  digest_q, digest_d;
  logic [HASH_W-1:0]  hash_in_q, hash_in_d;
  logic [BLK_W-1:0]   block_q, block_d;
  logic               start_q, start_d;
  logic               dvalid_q, dvalid_d;
  logic               err_q, err_d;
  logic               last_q, last_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               push, pop, fifo_empty, fifo_full;

  assign fifo_empty = (count_q == 2'd0);
  assign fifo_full  = (count_q == 2'd2);
  assign blk_ready  = !fifo_full && (state_q != S_ERR);
  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign push       = blk_valid && blk_ready;
  assign pop        = (state_q == S_IDLE) && !fifo_empty && core_ready;

  assign digest       = digest_q;
  assign digest_valid = dvalid_q;
  assign err_timeout  = err_q;
  assign core_start   = start_q;
  assign core_block   = block_q;
  assign core_hash_in = hash_in_q;

  // FIFO storage carries no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {blk_last, blk_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      h_q       <= IV;
      digest_q  <= '0;
      hash_in_q <= '0;
      block_q   <= '0;
      start_q   <= 1'b0;
      dvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      last_q    <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      h_q       <= h_d;
      digest_q  <= digest_d;
      hash_in_q <= hash_in_d;
      block_q   <= block_d;
      start_q   <= start_d;
      dvalid_q  <= dvalid_d;
      err_q     <= err_d;
      last_q    <= last_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    h_d       = h_q;
    digest_d  = digest_q;
    hash_in_d = hash_in_q;
    block_d   = block_q;
    start_d   = 1'b0;
    dvalid_d  = dvalid_q;
    err_d     = err_q;
    last_d    = last_q;
    tmo_d     = tmo_q;

    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          {last_d, block_d} = fifo_q[rd_ptr_q];
          hash_in_d = h_q;
          start_d   = 1'b1;
          tmo_d     = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        // a done in the final allowed cycle takes priority over the timeout
        if (core_done) begin
          h_d = core_hash;
          if (last_q) begin
            digest_d = core_hash;
            dvalid_d = 1'b1;
            state_d  = S_OUT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_d == TMO_W'(TIMEOUT_CYCLES)) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
      end
      S_OUT: begin
        if (digest_ready) begin
          dvalid_d = 1'b0;
          h_d      = IV;
          state_d  = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
